// File: rtl/rf_write_port_ctrl.sv
// Register-file write-port controller: merges ALU and buffered LSU results onto one
// write port with starvation-bounded arbitration, and keeps a busy scoreboard for decode.
module rf_write_port_ctrl #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        sleep_i,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_wdata_i,
  output logic        alu_stall_o,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic [4:0]  lsu_rd_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic        iss_valid_i,
  input  logic [4:0]  iss_rd_i,
  output logic        iss_rd_busy_o,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  output logic        rs1_busy_o,
  output logic        rs2_busy_o,
  output logic [4:0]  rd_o,
  output logic        we_o,
  output logic [31:0] wdata_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    fifo_rd   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;
  logic [31:0]   busy, busy_nxt;

  logic empty, full, force_head, alu_win, head_sel, commit, pop, push;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == SW'(STARVE_LIMIT)) ? v : v + SW'(1);
  endfunction

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign commit      = ~stall_i & ~sleep_i;
  assign force_head  = ~empty & (starve_cnt == SW'(STARVE_LIMIT));
  assign alu_win     = alu_valid_i & ~force_head;
  assign head_sel    = ~alu_win & ~empty;
  assign pop         = head_sel & commit;
  // Ready depends only on occupancy: a same-cycle pop never frees a slot for a push.
  assign push        = lsu_valid_i & ~full;
  assign lsu_ready_o = ~full;
  assign alu_stall_o = alu_valid_i & force_head;

  always_comb begin
    rd_o    = 5'd0;
    wdata_o = 32'd0;
    if (alu_win) begin
      rd_o    = alu_rd_i;
      wdata_o = alu_wdata_i;
    end else if (head_sel) begin
      rd_o    = fifo_rd[rd_ptr];
      wdata_o = fifo_data[rd_ptr];
    end
  end

  assign we_o = (alu_win | head_sel) & (rd_o != 5'd0);

  always_comb begin
    busy_nxt = busy;
    if (pop && we_o) busy_nxt[rd_o] = 1'b0;
    if (iss_valid_i && iss_rd_i != 5'd0) busy_nxt[iss_rd_i] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  assign rs1_busy_o    = busy[rs1_i];
  assign rs2_busy_o    = busy[rs2_i];
  assign iss_rd_busy_o = busy[iss_rd_i];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= lsu_rd_i;
      fifo_data[wr_ptr] <= lsu_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      busy       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (pop || empty) starve_cnt <= '0;
      else if (alu_win && commit) starve_cnt <= sat_inc(starve_cnt);
      busy <= busy_nxt;
    end
  end

endmodule

// File: doc/rf_write_port_ctrl.md
Name: rf_write_port_ctrl

Overview:
- Writer-side controller for the integer register file. Merges single-cycle ALU results and long-latency load/store-unit (LSU) results into the register file's single write port (rd / we / wdata).
- The register file commits a write only when stall and sleep are both low. This block uses the same commit rule, so a result is never dropped or double-written.
- Tracks in-flight long-latency destinations in a scoreboard, so decode can detect RAW and WAW hazards on rs1/rs2.

Parameters:
- DEPTH, 2, LSU result FIFO entries; power of two, 2 to 8.
- STARVE_LIMIT, 4, consecutive cycles the FIFO head may lose arbitration to the ALU before it is forced through; 1 to 15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  pipeline stall; blocks commit
- sleep_i  in  1  core sleep; blocks commit
- alu_valid_i  in  1  ALU result present this cycle
- alu_rd_i  in  5  ALU destination
- alu_wdata_i  in  32  ALU result
- alu_stall_o  out  1  ALU result not accepted this cycle; upstream must hold it
- lsu_valid_i  in  1  LSU result offered
- lsu_ready_o  out  1  FIFO can accept
- lsu_rd_i  in  5  LSU destination
- lsu_wdata_i  in  32  LSU result
- iss_valid_i  in  1  long-latency op issued
- iss_rd_i  in  5  its destination
- iss_rd_busy_o  out  1  busy[iss_rd_i]
- rs1_i, rs2_i  in  5 each  decode source indices
- rs1_busy_o, rs2_busy_o  out  1 each  busy[rs1_i], busy[rs2_i]
- rd_o  out  5  register-file write index
- we_o  out  1  register-file write enable
- wdata_o  out  32  register-file write data

Behaviour:
- commit = ~stall_i & ~sleep_i. This matches the register file's write qualifier exactly.
- FIFO:
  - Push when lsu_valid_i & lsu_ready_o.
  - lsu_ready_o = ~full. There is no pass-through when full, even if a pop occurs the same cycle.
  - Push and pop in the same cycle are allowed when not full.
  - Pointers wrap modulo DEPTH. Occupancy counts 0..DEPTH.
- Earliest write for an LSU result is the cycle after its push. There is no same-cycle bypass.
- Arbitration (combinational select):
  - force = ~empty & (starve_cnt == STARVE_LIMIT).
  - ALU wins when alu_valid_i & ~force. Otherwise the FIFO head is selected when not empty.
  - alu_stall_o = alu_valid_i & force.
  - rd_o/wdata_o come from the winner. When nothing is selected, they are 0.
- we_o = selected source valid & rd_o != 0.
- An rd = 0 entry still pops, with no write.
- Pop occurs when the head is selected & commit.
- starve_cnt:
  - Reset to 0 on any pop, or when the FIFO is empty.
  - Increment (saturating at STARVE_LIMIT) when ~empty & ALU wins & commit.
  - Frozen while commit = 0.
- Scoreboard: 32-bit busy vector. busy[0] is permanently 0.
  - Set: iss_valid_i & iss_rd_i != 0.
  - Clear: a FIFO pop with we_o = 1 clears busy[rd_o].
  - Set and clear of the same index in one cycle: set wins.
  - ALU writes never touch the scoreboard.
  - Issuing to an already-busy rd is illegal. The bench checks this with iss_rd_busy_o.
- Busy read outputs are combinational from the current busy register state (pre-update).
- Stall/sleep:
  - No pops, no scoreboard clears.
  - Pushes and issues continue.
  - Outputs stay stable while their inputs are stable.
- Reset (asynchronous, any time, including mid-operation):
  - FIFO empty, pointers 0, starve_cnt 0, busy all 0.
  - With alu_valid_i = 0: we_o = 0, rd_o = 0, wdata_o = 0, lsu_ready_o = 1, alu_stall_o = 0.
  - An entry in flight at reset is discarded.

Test Plan:
1. Reset, then push LSU rd=5, data 0xDEADBEEF at cycle T, ALU idle -> at T+1: we_o=1, rd_o=5, wdata_o=0xDEADBEEF. At T+2: FIFO empty, lsu_ready_o=1, we_o=0.
2. FIFO head rd=3, data 0x11; alu_valid_i held with rd=7 -> four cycles write rd 7. Fifth cycle: alu_stall_o=1, rd_o=3, wdata_o=0x11, pop. Sixth cycle: rd_o=7, alu_stall_o=0.
3. DEPTH=2, ALU busy with starvation blocked by a long stall, two LSU pushes -> lsu_ready_o=0. Third offer is held until the first pop; no data lost; order preserved.
4. Head rd=9, stall_i=1 for 3 cycles, then sleep_i=1 for 2 cycles -> no pop, rd_o=9 constant, busy[9]=1 throughout. Pop and clear occur in the first cycle both are low.
5. Scoreboard:
   - Issue rd=12; rs1_i=12 -> rs1_busy_o=1 next cycle.
   - Commit LSU rd=12 while issuing rd=12 the same cycle -> busy stays 1.
   - Issue rd=0 -> rs2_i=0 gives rs2_busy_o=0.
6. Two FIFO entries plus busy bits set; assert rst_n=0 mid-cycle -> immediately the FIFO is empty, all busy outputs are 0, and we_o=0. After release, normal operation resumes with the first new push.
